// File: rtl/uart_rx_byte_if.sv
// Serial-side and byte-side signals of the boot-load UART receiver.
// master drives the line and bit period; slave is the receiver.
interface uart_rx_byte_if #(
    parameter int unsigned CPB_W = 16
);
    logic [CPB_W-1:0] clks_per_bit_i;
    logic             rx_i;
    logic             rx_dv_o;
    logic [7:0]       rx_byte_o;
    logic             frame_err_o;
    logic             busy_o;

    modport master (
        output clks_per_bit_i,
        output rx_i,
        input  rx_dv_o,
        input  rx_byte_o,
        input  frame_err_o,
        input  busy_o
    );

    modport slave (
        input  clks_per_bit_i,
        input  rx_i,
        output rx_dv_o,
        output rx_byte_o,
        output frame_err_o,
        output busy_o
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a run-time bit period; one-cycle pulse per good byte,
// frames with a low stop bit are dropped and flagged.
module uart_rx_byte #(
    parameter int unsigned CPB_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    uart_rx_byte_if.slave     bus
);
    localparam int unsigned CPB_MIN = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [CPB_W-1:0]   r_cpb;
    logic [CPB_W-1:0]   r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shreg;
    logic               r_rx_dv;
    logic [7:0]         r_rx_byte;
    logic               r_frame_err;
    logic               r_busy;

    logic [CPB_W-1:0]   w_cpb_in;
    logic [CPB_W-1:0]   w_half;
    logic [CPB_W-1:0]   w_last;
    logic               w_tick;
    logic [CPB_W-1:0]   w_cpb_nxt;
    logic [CPB_W-1:0]   w_clk_cnt_nxt;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         w_shreg_nxt;
    logic               w_rx_dv_nxt;
    logic [7:0]         w_rx_byte_nxt;
    logic               w_frame_err_nxt;
    logic               w_busy_nxt;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_cpb_in = (bus.clks_per_bit_i < CPB_W'(CPB_MIN)) ? CPB_W'(CPB_MIN)
                                                             : bus.clks_per_bit_i;
    assign w_half   = r_cpb >> 1;
    assign w_last   = r_cpb - CPB_W'(1);
    assign w_tick   = ((r_state == S_START) && (r_clk_cnt == w_half)) ||
                      (((r_state == S_DATA) || (r_state == S_STOP)) && (r_clk_cnt == w_last));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!r_rx_s) w_state_nxt = S_START;
            S_START: if (w_tick) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
            S_STOP:  if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cpb_nxt       = r_cpb;
        w_clk_cnt_nxt   = r_clk_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shreg_nxt     = r_shreg;
        w_rx_dv_nxt     = 1'b0;
        w_rx_byte_nxt   = r_rx_byte;
        w_frame_err_nxt = 1'b0;
        w_busy_nxt      = (w_state_nxt != S_IDLE);

        // Counter restarts on each sample and state change, otherwise saturates
        if ((r_state == S_IDLE) || w_tick || (w_state_nxt != r_state)) begin
            w_clk_cnt_nxt = '0;
        end else if (r_clk_cnt != w_last) begin
            w_clk_cnt_nxt = r_clk_cnt + CPB_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_cpb_nxt = w_cpb_in;
            end
            S_START: begin
                if (w_tick && !r_rx_s) w_bit_idx_nxt = 3'd0;
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shreg_nxt[r_bit_idx] = r_rx_s;
                    w_bit_idx_nxt          = r_bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_rx_dv_nxt   = 1'b1;
                        w_rx_byte_nxt = r_shreg;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cpb       <= '0;
            r_clk_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'h00;
            r_rx_dv     <= 1'b0;
            r_rx_byte   <= 8'h00;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cpb       <= w_cpb_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_rx_dv     <= w_rx_dv_nxt;
            r_rx_byte   <= w_rx_byte_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.rx_dv_o     = r_rx_dv;
    assign bus.rx_byte_o   = r_rx_byte;
    assign bus.frame_err_o = r_frame_err;
    assign bus.busy_o      = r_busy;
endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed frames, an event-list model of expected
// pulses checked every cycle, plus literal spot checks.
module tb_uart_rx_byte;
    localparam int unsigned CPB_W = 16;

    typedef struct {
        int unsigned cyc;
        bit          err;
        logic [7:0]  data;
    } ev_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned n_pass;
    int unsigned n_chk;
    ev_t         evq[$];
    int unsigned dvq[$];
    logic [7:0]  exp_byte;

    uart_rx_byte_if #(.CPB_W(CPB_W)) bus ();

    uart_rx_byte #(.CPB_W(CPB_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Per-cycle compare against the expected-event list
    always @(negedge clk) begin
        logic e_dv;
        logic e_fe;
        if (rst) begin
            evq.delete();
            exp_byte = 8'h00;
            chk("rst_dv", 32'(bus.rx_dv_o), 32'd0);
            chk("rst_ferr", 32'(bus.frame_err_o), 32'd0);
            chk("rst_byte", 32'(bus.rx_byte_o), 32'd0);
        end else begin
            e_dv = 1'b0;
            e_fe = 1'b0;
            for (int i = int'(evq.size()) - 1; i >= 0; i--) begin
                if (evq[i].cyc == cyc) begin
                    if (evq[i].err) e_fe = 1'b1;
                    else begin
                        e_dv     = 1'b1;
                        exp_byte = evq[i].data;
                    end
                    evq.delete(i);
                end
            end
            chk("dv", 32'(bus.rx_dv_o), 32'(e_dv));
            chk("ferr", 32'(bus.frame_err_o), 32'(e_fe));
            chk("byte", 32'(bus.rx_byte_o), 32'(exp_byte));
            if (bus.rx_dv_o === 1'b1) dvq.push_back(cyc);
        end
    end

    task automatic idle(input int unsigned n);
        bus.rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame at bitper clocks/bit; queue the pulse the spec predicts
    task automatic send_frame(input logic [7:0] data, input logic stopv,
                              input int unsigned bitper, input logic [CPB_W-1:0] mid_cpb,
                              output int unsigned e);
        int unsigned eff;
        ev_t ev;
        eff = (int'(bus.clks_per_bit_i) < 4) ? 4 : int'(bus.clks_per_bit_i);
        bus.rx_i = 1'b0;
        e = cyc + 1;
        ev.cyc  = e + 3 + eff / 2 + 9 * eff;
        ev.err  = !stopv;
        ev.data = data;
        evq.push_back(ev);
        repeat (bitper) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus.rx_i = data[i];
            if (i == 1) bus.clks_per_bit_i = mid_cpb;
            repeat (bitper) @(posedge clk);
            #1;
        end
        bus.rx_i = stopv;
        repeat (bitper) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned e;
        logic [7:0] partial;
        cyc      = 0;
        n_pass   = 0;
        n_chk    = 0;
        exp_byte = 8'h00;
        rst      = 1'b1;
        bus.rx_i = 1'b1;
        bus.clks_per_bit_i = CPB_W'(8);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;
        idle(10);

        // 1: 0xA5 at cpb=8, pulse lands exactly when the stop bit completes (E+79)
        send_frame(8'hA5, 1'b1, 8, CPB_W'(8), e);
        chk("t1_dv_at_79", 32'(bus.rx_dv_o), 32'd1);
        chk("t1_byte", 32'(bus.rx_byte_o), 32'hA5);
        chk("t1_busy", 32'(bus.busy_o), 32'd0);
        idle(1);
        chk("t1_dv_1cyc", 32'(bus.rx_dv_o), 32'd0);
        idle(20);

        // 2: two-cycle glitch
        bus.rx_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.rx_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t2_busy_hi", 32'(bus.busy_o), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_busy_lo", 32'(bus.busy_o), 32'd0);
        idle(20);

        // 3: bad stop bit
        send_frame(8'h3C, 1'b0, 8, CPB_W'(8), e);
        chk("t3_ferr", 32'(bus.frame_err_o), 32'd1);
        chk("t3_dv", 32'(bus.rx_dv_o), 32'd0);
        chk("t3_byte_kept", 32'(bus.rx_byte_o), 32'hA5);
        idle(30);

        // 4: back-to-back frames
        dvq.delete();
        send_frame(8'h00, 1'b1, 8, CPB_W'(8), e);
        send_frame(8'h00, 1'b1, 8, CPB_W'(8), e);
        send_frame(8'h0F, 1'b1, 8, CPB_W'(8), e);
        send_frame(8'hFF, 1'b1, 8, CPB_W'(8), e);
        chk("t4_last_byte", 32'(bus.rx_byte_o), 32'hFF);
        idle(10);
        chk("t4_pulses", 32'(dvq.size()), 32'd4);
        for (int i = 1; i < int'(dvq.size()); i++)
            chk("t4_spacing", dvq[i] - dvq[i-1], 32'd80);

        // 5: reset during data bit 4 of 0x5A, then 0xC3 at cpb=16
        bus.clks_per_bit_i = CPB_W'(16);
        idle(10);
        partial = 8'h5A;
        bus.rx_i = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.rx_i = partial[i];
            repeat ((i == 4) ? 8 : 16) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy_o), 32'd0);
        chk("t5_byte", 32'(bus.rx_byte_o), 32'd0);
        chk("t5_dv", 32'(bus.rx_dv_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(40);
        dvq.delete();
        send_frame(8'hC3, 1'b1, 16, CPB_W'(16), e);
        chk("t5_byte_c3", 32'(bus.rx_byte_o), 32'hC3);
        chk("t5_one_pulse", 32'(dvq.size()), 32'd1);
        if (dvq.size() > 0) chk("t5_latency", dvq[0] - e, 32'd155);
        idle(20);

        // 6: 115200 baud at 100 MHz with a mid-frame cpb change, then cpb=2 forced to 4
        bus.clks_per_bit_i = CPB_W'(868);
        idle(20);
        send_frame(8'h13, 1'b1, 868, CPB_W'(2), e);
        chk("t6_byte_13", 32'(bus.rx_byte_o), 32'h13);
        idle(10);
        send_frame(8'h81, 1'b1, 4, CPB_W'(2), e);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_dv_81", 32'(bus.rx_dv_o), 32'd1);
        chk("t6_byte_81", 32'(bus.rx_byte_o), 32'h81);

        idle(20);
        chk("all_events_seen", 32'(evq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
